// File: rtl/button_press_classifier.sv
// Button front end: 2-FF synchronizer, tick-based debouncer and a hold-time
// classifier that turns one physical button into short/long/repeat events.
//
// state | meaning
// IDLE  | debounced button released, waiting for a press
// HELD  | pressed, counting ticks toward the long threshold
// LONG  | held past the long threshold, issuing auto-repeat pulses
`timescale 1ns/1ps

module button_press_classifier #(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000,
  parameter int unsigned REPEAT_TICKS   = 200,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic pressed,
  output logic inc_short,
  output logic inc_long,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // Terminal-count compare values; a zero repeat interval disables the
  // repeat counter entirely, so its terminal value is never used then.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  =
    CNT_W'((REPEAT_TICKS == 0) ? 0 : (REPEAT_TICKS - 1));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               REPEAT_EN = (REPEAT_TICKS != 0);

  logic             sync1_q, sync2_q;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             inc_short_q, inc_short_d;
  logic             inc_long_q, inc_long_d;
  logic             repeat_q, repeat_d;

  // Two-flop synchronizer for the asynchronous raw button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatching ticks; any return to the
  // accepted level restarts the count, a tickless mismatch just holds it.
  always_comb begin
    pressed_d = pressed_q;
    db_cnt_d  = db_cnt_q;
    if (sync2_q == pressed_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = sync2_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
  end

  // Debounced level and its mismatch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Classifier next-state and registered-output decode; pulses default low.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    inc_short_d = 1'b0;
    inc_long_d  = inc_long_q;
    repeat_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        inc_long_d = 1'b0;
        if (pressed_q) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end
      end

      ST_HELD: begin
        // Release is checked first so a release coinciding with the
        // threshold tick still counts as a short press.
        if (!pressed_q) begin
          state_d     = ST_IDLE;
          inc_short_d = 1'b1;
          hold_cnt_d  = '0;
        end else if (tick) begin
          if (hold_cnt_q == LONG_LAST) begin
            state_d    = ST_LONG;
            inc_long_d = 1'b1;
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
      end

      ST_LONG: begin
        if (!pressed_q) begin
          state_d    = ST_IDLE;
          inc_long_d = 1'b0;
          rep_cnt_d  = '0;
        end else if (tick && REPEAT_EN) begin
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        inc_long_d = 1'b0;
      end
    endcase
  end

  // Classifier state, hold/repeat counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      inc_short_q <= 1'b0;
      inc_long_q  <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      inc_short_q <= inc_short_d;
      inc_long_q  <= inc_long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign pressed      = pressed_q;
  assign inc_short    = inc_short_q;
  assign inc_long     = inc_long_q;
  assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: stimulus pushes expected output events (kind + cycle),
// a separate monitor pops and compares whenever an output event appears.
`timescale 1ns/1ps

module tb_button_press_classifier;

  localparam int K_PRISE = 0;
  localparam int K_PFALL = 1;
  localparam int K_LRISE = 2;
  localparam int K_LFALL = 3;
  localparam int K_SHORT = 4;
  localparam int K_REP   = 5;
  localparam int K_REP0  = 6;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b1;
  logic btn_raw = 1'b0;
  logic sparse = 1'b0;

  logic pressed, inc_short, inc_long, repeat_pulse;
  logic pressed0, inc_short0, inc_long0, repeat_pulse0;

  int   cyc = 0;
  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   drain_seq = 0;

  button_press_classifier #(
    .DEBOUNCE_TICKS(4), .LONG_TICKS(10), .REPEAT_TICKS(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_raw),
    .pressed(pressed), .inc_short(inc_short), .inc_long(inc_long),
    .repeat_pulse(repeat_pulse)
  );

  // Same configuration with auto-repeat disabled.
  button_press_classifier #(
    .DEBOUNCE_TICKS(4), .LONG_TICKS(10), .REPEAT_TICKS(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_raw),
    .pressed(pressed0), .inc_short(inc_short0), .inc_long(inc_long0),
    .repeat_pulse(repeat_pulse0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: every clk, or one clk in five (edges where cyc%5==0).
  initial begin
    forever begin
      @(negedge clk);
      tick = !sparse || (((cyc + 1) % 5) == 0);
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_PRISE: return "pressed_rise";
      K_PFALL: return "pressed_fall";
      K_LRISE: return "inc_long_rise";
      K_LFALL: return "inc_long_fall";
      K_SHORT: return "inc_short";
      K_REP:   return "repeat_pulse";
      K_REP0:  return "repeat_pulse_norep";
      default: return "unknown";
    endcase
  endfunction

  // Called only by the monitor: pop the next expectation and compare.
  task automatic got_event(input int kind, input int at);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got %s at cycle %0d, required no event", kname(kind), at);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.cyc == at) n_pass++;
      else $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                    kname(kind), at, kname(e.kind), e.cyc);
    end
  endtask

  // Monitor: detects output events on the falling edge and scores them.
  initial begin : monitor
    logic prev_p, prev_l, rst_seen;
    int   drain_seen;
    ev_t  e;
    prev_p = 1'b0;
    prev_l = 1'b0;
    rst_seen = 1'b0;
    drain_seen = 0;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        if (!rst_seen) begin
          #1;
          n_checks++;
          if ({pressed, inc_short, inc_long, repeat_pulse} == 4'b0000) n_pass++;
          else $display("FAIL reset_outputs: got %b%b%b%b required 0000",
                        pressed, inc_short, inc_long, repeat_pulse);
          n_checks++;
          if ({pressed0, inc_short0, inc_long0, repeat_pulse0} == 4'b0000) n_pass++;
          else $display("FAIL reset_outputs_norep: got %b%b%b%b required 0000",
                        pressed0, inc_short0, inc_long0, repeat_pulse0);
          rst_seen = 1'b1;
        end
        prev_p = 1'b0;
        prev_l = 1'b0;
      end else begin
        rst_seen = 1'b0;
        if (pressed != prev_p) begin
          got_event(pressed ? K_PRISE : K_PFALL, cyc);
          prev_p = pressed;
        end
        if (inc_long != prev_l) begin
          got_event(inc_long ? K_LRISE : K_LFALL, cyc);
          prev_l = inc_long;
        end
        if (inc_short) got_event(K_SHORT, cyc);
        if (repeat_pulse) got_event(K_REP, cyc);
        if (repeat_pulse0) got_event(K_REP0, cyc);
        if (drain_seq != drain_seen) begin
          n_checks++;
          if (exp_q.size() == 0) n_pass++;
          else begin
            e = exp_q[0];
            $display("FAIL drain: %0d expected events never seen, first %s at cycle %0d",
                     exp_q.size(), kname(e.kind), e.cyc);
            exp_q.delete();
          end
          drain_seen = drain_seq;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    step(4);
    drain_seq++;
    step(2);
  endtask

  // Stimulus: directed scenarios with hand-derived event cycles.
  initial begin : stimulus
    int t0, r;
    int highs[10];
    int lows[10];
    highs = '{1, 3, 2, 3, 1, 2, 3, 1, 2, 3};
    lows  = '{1, 1, 2, 1, 1, 1, 1, 2, 1, 1};

    step(3);
    reset = 1'b0;
    step(3);

    // Clean short press.
    t0 = cyc;
    btn_raw = 1'b1;
    push(K_PRISE, t0 + 6);
    push(K_PFALL, t0 + 14);
    push(K_SHORT, t0 + 15);
    step(8);
    btn_raw = 1'b0;
    step(12);
    drain();

    // Bounce rejection: high runs of 1..3 clks never survive debounce.
    for (int i = 0; i < 10; i++) begin
      btn_raw = 1'b1;
      step(highs[i]);
      btn_raw = 1'b0;
      step(lows[i]);
    end
    step(10);
    drain();

    // Long hold with auto-repeat.
    t0 = cyc;
    btn_raw = 1'b1;
    push(K_PRISE, t0 + 6);
    push(K_LRISE, t0 + 17);
    push(K_REP,   t0 + 17);
    push(K_REP0,  t0 + 17);
    for (int k = 20; k <= 35; k += 3) push(K_REP, t0 + k);
    push(K_PFALL, t0 + 36);
    push(K_LFALL, t0 + 37);
    step(30);
    btn_raw = 1'b0;
    step(12);
    drain();

    // Release lands on the same clk as the long threshold tick.
    t0 = cyc;
    btn_raw = 1'b1;
    push(K_PRISE, t0 + 6);
    push(K_PFALL, t0 + 16);
    push(K_SHORT, t0 + 17);
    step(10);
    btn_raw = 1'b0;
    step(12);
    drain();

    // Sparse tick: accepted press after 4 ticks, then a 3-tick pulse rejected.
    sparse = 1'b1;
    step(2);
    while ((cyc % 5) != 0) step(1);
    t0 = cyc;
    btn_raw = 1'b1;
    push(K_PRISE, t0 + 20);
    push(K_PFALL, t0 + 45);
    push(K_SHORT, t0 + 46);
    step(25);
    btn_raw = 1'b0;
    step(25);
    drain();
    while ((cyc % 5) != 2) step(1);
    btn_raw = 1'b1;
    step(12);
    btn_raw = 1'b0;
    step(10);
    drain();
    sparse = 1'b0;
    step(3);

    // Reset mid-LONG with a repeat pending, button still held afterwards.
    t0 = cyc;
    btn_raw = 1'b1;
    push(K_PRISE, t0 + 6);
    push(K_LRISE, t0 + 17);
    push(K_REP,   t0 + 17);
    push(K_REP0,  t0 + 17);
    push(K_REP,   t0 + 20);
    push(K_REP,   t0 + 23);
    step(24);
    @(posedge clk);
    #2 reset = 1'b1;
    step(3);
    reset = 1'b0;
    r = cyc;
    push(K_PRISE, r + 6);
    push(K_LRISE, r + 17);
    push(K_REP,   r + 17);
    push(K_REP0,  r + 17);
    push(K_REP,   r + 20);
    push(K_REP,   r + 23);
    push(K_REP,   r + 26);
    push(K_PFALL, r + 27);
    push(K_LFALL, r + 28);
    step(21);
    btn_raw = 1'b0;
    step(12);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
